fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 90 +++++++++
 tb/tb_fetch_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Instruction fetch queue. Fetches one word per cycle from a
//            combinational instruction memory into a circular buffer of
//            {instr, pc+4} entries; the consumer pops the head entry unless
//            stalled. A flush discards the buffer and redirects fetch.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [31:0]              flush_pc,
  output logic [31:0]              ins_out,
  output logic [31:0]              pc4_out,
  output logic                     valid_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(DEPTH);

  logic [31:0]        r_fpc;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w:0]   r_count;

  // Entry storage carries no reset; validity is tracked by r_count alone.
  logic [31:0]        r_instr_mem [DEPTH];
  logic [31:0]        r_pc4_mem   [DEPTH];

  logic               w_pop;
  logic               w_push;
  logic [31:0]        w_fpc_plus4;

  // A full queue may still accept a new word in the same cycle the head leaves.
  assign w_pop       = valid_out & ~stall & ~flush;
  assign w_push      = ~flush & ((r_count < c_depth) | w_pop);
  assign w_fpc_plus4 = r_fpc + 32'd4;

  assign imem_addr = r_fpc;
  assign count     = r_count;
  assign valid_out = (r_count != '0);
  assign ins_out   = r_instr_mem[r_rd_ptr];
  assign pc4_out   = r_pc4_mem[r_rd_ptr];

  // Fetch pointer, queue pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpc    <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_fpc    <= flush_pc;
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fpc    <= w_fpc_plus4;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Capture the fetched word and its return address at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push && rst_n) begin
      r_instr_mem[r_wr_ptr] <= imem_data;
      r_pc4_mem[r_wr_ptr]   <= w_fpc_plus4;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Directed bench for fetch_queue. Stimulus queues the expected
//            {instr, pc+4} of every entry it intends the consumer to pop; a
//            monitor pops and compares on each consumer handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] ins_out;
  logic [31:0] pc4_out;
  logic        valid_out;
  logic [$clog2(DEPTH):0] count;

  int n_chk;
  int n_err;

  logic [63:0] sb [$];

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .stall     (stall),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .ins_out   (ins_out),
    .pc4_out   (pc4_out),
    .valid_out (valid_out),
    .count     (count)
  );

  // Instruction memory model: word content is its own address tagged.
  assign imem_data = imem_addr | 32'hA000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input logic [31:0] addr);
    sb.push_back({addr | 32'hA000_0000, addr + 32'd4});
  endfunction

  // Advance one clock and land just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumer handshake must match the oldest expected entry.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && valid_out === 1'b1 && stall === 1'b0 && flush === 1'b0) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_unexpected_pop: got pc4 %h expected no pop", pc4_out);
        end else begin
          e = sb.pop_front();
          chk("sb_ins", ins_out, e[63:32]);
          chk("sb_pc4", pc4_out, e[31:0]);
        end
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pat;
    bit          drained;
    pat      = 16'b0110_1001_1100_0101;
    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    stall    = 1'b1;
    flush    = 1'b0;
    flush_pc = 32'h0;

    // Reset state
    #12;
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_push_count", 32'(count), 32'd1);

    // Fill under stall
    repeat (3) step();
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_addr", imem_addr, 32'd16);
    chk("fill_ins", ins_out, 32'hA000_0000);
    chk("fill_pc4", pc4_out, 32'd4);
    repeat (2) step();
    chk("full_hold_addr", imem_addr, 32'd16);
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_hold_ins", ins_out, 32'hA000_0000);

    // Full with one pop
    push_exp(32'd0);
    stall = 1'b0;
    step();
    stall = 1'b1;
    chk("fullpop_count", 32'(count), 32'd4);
    chk("fullpop_ins", ins_out, 32'hA000_0004);
    chk("fullpop_pc4", pc4_out, 32'd8);
    chk("fullpop_addr", imem_addr, 32'd20);

    // Refill to three entries from 0
    flush = 1'b1;
    flush_pc = 32'd0;
    step();
    flush = 1'b0;
    repeat (3) step();
    chk("three_count", 32'(count), 32'd3);

    // Flush precedence with stall low
    stall = 1'b0;
    flush = 1'b1;
    flush_pc = 32'h0000_0100;
    for (int i = 0; i < 7; i++) push_exp(32'h100 + 32'(4 * i));
    step();
    flush = 1'b0;
    chk("flush_valid", {31'd0, valid_out}, 32'd0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_addr", imem_addr, 32'h100);
    step();
    chk("redir_valid", {31'd0, valid_out}, 32'd1);
    chk("redir_pc4", pc4_out, 32'h104);

    // Streaming: one entry in flight, head advances every cycle
    for (int i = 1; i < 7; i++) begin
      step();
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_ins", ins_out, (32'h100 + 32'(4 * i)) | 32'hA000_0000);
    end
    step();
    stall = 1'b1;
    chk("stream_pc4", pc4_out, 32'h120);

    // Address wrap
    flush = 1'b1;
    flush_pc = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    chk("wrap_flush_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_count", 32'(count), 32'd1);
    chk("wrap_ins", ins_out, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4_out, 32'd0);
    chk("wrap_addr", imem_addr, 32'd0);

    // Pointer wrap with irregular stall, scoreboard-checked
    for (int k = 0; k < 16; k++) push_exp(32'hFFFF_FFFC + 32'(4 * k));
    drained = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (sb.size() == 0) begin
        drained = 1'b1;
        break;
      end
      stall = pat[c % 16];
      step();
    end
    stall = 1'b1;
    chk("drain_done", {31'd0, drained}, 32'd1);

    // Async reset mid-fill
    flush = 1'b1;
    flush_pc = 32'd0;
    step();
    flush = 1'b0;
    repeat (2) step();
    chk("pre_rst_count", 32'(count), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, valid_out}, 32'd0);
    chk("arst_addr", imem_addr, RESET_PC);
    chk("arst_count", 32'(count), 32'd0);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_addr", imem_addr, RESET_PC + 32'd4);
    chk("post_rst_pc4", pc4_out, RESET_PC + 32'd4);

    repeat (2) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
